// File: rtl/link_monitor_pkg.sv
// Shared state encoding, widths and saturating helper for the link_monitor supervisor.
package link_monitor_pkg;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StInit      = 3'd1,
      StWaitAlign = 3'd2,
      StTrain     = 3'd3,
      StUp        = 3'd4
   } state_e;

   localparam int unsigned DeltaW  = 8;
   localparam int unsigned WinErrW = 16;

   function automatic logic [WinErrW-1:0] sat_add(input logic [WinErrW-1:0] a,
                                                  input logic [DeltaW-1:0]  b);
      logic [WinErrW:0] s;
      s = {1'b0, a} + {{(WinErrW + 1 - DeltaW){1'b0}}, b};
      return s[WinErrW] ? {WinErrW{1'b1}} : s[WinErrW-1:0];
   endfunction

endpackage

// File: rtl/lm_window.sv
// Fixed-length error window: counts cycles while running, accumulates deltas with
// saturation and publishes the completed window's total.
module lm_window
   import link_monitor_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = 10,
   parameter int unsigned ERR_TH   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               run_i,
   input  logic               clr_i,
   input  logic [DeltaW-1:0]  delta_i,
   output logic [WinErrW-1:0] win_err_o,
   output logic               win_done_o,
   output logic               win_bad_o
);

   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [WinErrW-1:0]  acc_q, acc_d;
   logic [WinErrW-1:0]  win_err_q, win_err_d;
   logic [WinErrW-1:0]  sum;

   always_comb begin
      sum        = sat_add(acc_q, delta_i);
      win_done_o = run_i && !clr_i && (cnt_q == {WIN_LOG2{1'b1}});
      win_bad_o  = (sum >= WinErrW'(ERR_TH));
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      win_err_d  = win_err_q;
      if (clr_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (run_i) begin
         // Counter wraps to zero after all-ones, starting the next window.
         cnt_d = cnt_q + 1'b1;
         if (win_done_o) begin
            win_err_d = sum;
            acc_d     = '0;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         win_err_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         win_err_q <= win_err_d;
      end
   end

   assign win_err_o = win_err_q;

endmodule

// File: rtl/link_monitor.sv
// Link-health supervisor: converts the link's running error counter into per-window
// statistics and runs the bring-up / retrain state machine that requests PHY re-init.
module link_monitor
   import link_monitor_pkg::*;
#(
   parameter int unsigned WIN_LOG2  = 10,
   parameter int unsigned ERR_TH    = 4,
   parameter int unsigned UP_WINS   = 4,
   parameter int unsigned DOWN_WINS = 2,
   parameter int unsigned INIT_CYC  = 64,
   parameter int unsigned TO_WINS   = 4,
   parameter int unsigned TOT_W     = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic [7:0]       ERR_CNT,
   input  logic             ALIGNED,
   output logic             RETRAIN,
   output logic             LINK_UP,
   output logic             DEGRADED,
   output logic [15:0]      WIN_ERR,
   output logic [TOT_W-1:0] TOT_ERR,
   output logic [2:0]       STATE
);

   localparam int unsigned ToCyc  = TO_WINS << WIN_LOG2;
   localparam int unsigned InitW  = $clog2(INIT_CYC + 1);
   localparam int unsigned ToW    = $clog2(ToCyc + 1);
   localparam int unsigned CleanW = $clog2(UP_WINS + 1);
   localparam int unsigned BadW   = $clog2(DOWN_WINS + 1);

   logic [DeltaW-1:0] err_q, err_d, err_p_q, err_p_d, delta;
   logic              primed_q, primed_d, valid_q, valid_d;
   logic [TOT_W-1:0]  tot_q, tot_d;
   logic [TOT_W:0]    tot_sum;
   state_e            state_q, state_d;
   logic [InitW-1:0]  init_q, init_d;
   logic [ToW-1:0]    to_q, to_d;
   logic [CleanW-1:0] clean_q, clean_d;
   logic [BadW-1:0]   bad_q, bad_d;
   logic              win_run, win_done, win_bad;

   // Two-deep valid: the first post-reset sample only seeds err_p, so no bogus delta.
   always_comb begin
      err_d    = ERR_CNT;
      err_p_d  = err_q;
      primed_d = 1'b1;
      valid_d  = primed_q;
      delta    = valid_q ? DeltaW'(err_q - err_p_q) : '0;
      tot_sum  = {1'b0, tot_q} + (TOT_W + 1)'(delta);
      tot_d    = tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];
   end

   assign win_run = (state_q == StTrain) || (state_q == StUp);

   lm_window #(
      .WIN_LOG2 (WIN_LOG2),
      .ERR_TH   (ERR_TH)
   ) u_window (
      .clk_i      (CLK),
      .rst_i      (RST),
      .run_i      (win_run),
      .clr_i      (!win_run),
      .delta_i    (delta),
      .win_err_o  (WIN_ERR),
      .win_done_o (win_done),
      .win_bad_o  (win_bad)
   );

   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      to_d    = to_q;
      clean_d = clean_q;
      bad_d   = bad_q;
      if (!ENABLE) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: state_d = StInit;
            StInit: begin
               if (init_q == InitW'(INIT_CYC - 1)) state_d = StWaitAlign;
               else init_d = init_q + 1'b1;
            end
            StWaitAlign: begin
               if (ALIGNED) state_d = StTrain;
               else if (to_q == ToW'(ToCyc - 1)) state_d = StInit;
               else to_d = to_q + 1'b1;
            end
            StTrain: begin
               if (!ALIGNED) begin
                  state_d = StInit;
               end else if (win_done) begin
                  if (win_bad) clean_d = '0;
                  else if (clean_q + 1'b1 == CleanW'(UP_WINS)) state_d = StUp;
                  else clean_d = clean_q + 1'b1;
               end
            end
            StUp: begin
               if (!ALIGNED) begin
                  state_d = StInit;
               end else if (win_done) begin
                  if (!win_bad) bad_d = '0;
                  else if (bad_q + 1'b1 == BadW'(DOWN_WINS)) state_d = StInit;
                  else bad_d = bad_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      // Every state entry starts its counters from zero.
      if (state_d != state_q) begin
         init_d  = '0;
         to_d    = '0;
         clean_d = '0;
         bad_d   = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_q    <= '0;
         err_p_q  <= '0;
         primed_q <= 1'b0;
         valid_q  <= 1'b0;
         tot_q    <= '0;
         state_q  <= StIdle;
         init_q   <= '0;
         to_q     <= '0;
         clean_q  <= '0;
         bad_q    <= '0;
      end else begin
         err_q    <= err_d;
         err_p_q  <= err_p_d;
         primed_q <= primed_d;
         valid_q  <= valid_d;
         tot_q    <= tot_d;
         state_q  <= state_d;
         init_q   <= init_d;
         to_q     <= to_d;
         clean_q  <= clean_d;
         bad_q    <= bad_d;
      end
   end

   assign RETRAIN  = (state_q == StInit);
   assign LINK_UP  = (state_q == StUp);
   assign DEGRADED = (state_q == StUp) && (bad_q != '0);
   assign TOT_ERR  = tot_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_link_monitor.sv
// Self-checking bench for link_monitor: directed bring-up/wrap/degrade/timeout/priority
// scenarios plus randomized traffic, all checked against a behavioural model.
module tb_link_monitor;

   localparam int WinLog2  = 4;
   localparam int ErrTh    = 2;
   localparam int UpWins   = 2;
   localparam int DownWins = 2;
   localparam int InitCyc  = 8;
   localparam int ToWins   = 4;
   localparam int TotW     = 8;
   localparam int Win      = 1 << WinLog2;
   localparam int TotMax   = (1 << TotW) - 1;

   logic            CLK;
   logic            RST;
   logic            ENABLE;
   logic [7:0]      ERR_CNT;
   logic            ALIGNED;
   logic            RETRAIN;
   logic            LINK_UP;
   logic            DEGRADED;
   logic [15:0]     WIN_ERR;
   logic [TotW-1:0] TOT_ERR;
   logic [2:0]      STATE;

   link_monitor #(
      .WIN_LOG2  (WinLog2),
      .ERR_TH    (ErrTh),
      .UP_WINS   (UpWins),
      .DOWN_WINS (DownWins),
      .INIT_CYC  (InitCyc),
      .TO_WINS   (ToWins),
      .TOT_W     (TotW)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ENABLE   (ENABLE),
      .ERR_CNT  (ERR_CNT),
      .ALIGNED  (ALIGNED),
      .RETRAIN  (RETRAIN),
      .LINK_UP  (LINK_UP),
      .DEGRADED (DEGRADED),
      .WIN_ERR  (WIN_ERR),
      .TOT_ERR  (TOT_ERR),
      .STATE    (STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks;
   int n_pass;

   // Behavioural model state (states: 0 idle, 1 init, 2 wait-align, 3 train, 4 up).
   int m_state, m_time, m_clean, m_bad, m_pos, m_sum, m_win_err, m_tot;
   bit m_done;
   int m_hist[$];
   int rates[4] = '{0, 1, 3, 8};

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 0; m_time = 0; m_clean = 0; m_bad = 0;
      m_pos = 0; m_sum = 0; m_win_err = 0; m_tot = 0; m_done = 0;
      m_hist.delete();
   endtask

   // One clock edge of the specified behaviour, using the inputs sampled at that edge.
   task automatic model_step();
      int delta;
      int nxt;
      bit bad;
      delta  = 0;
      bad    = 0;
      m_done = 0;
      if (m_hist.size() >= 2) delta = (m_hist[m_hist.size()-1] - m_hist[m_hist.size()-2] + 256) % 256;
      m_hist.push_back(int'(ERR_CNT));
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      m_tot = (m_tot + delta > TotMax) ? TotMax : m_tot + delta;
      if (m_state == 3 || m_state == 4) begin
         m_sum += delta;
         if (m_pos == Win - 1) begin
            m_done    = 1;
            m_win_err = (m_sum > 65535) ? 65535 : m_sum;
            bad       = (m_sum >= ErrTh);
            m_sum     = 0;
            m_pos     = 0;
         end else begin
            m_pos++;
         end
      end else begin
         m_pos = 0;
         m_sum = 0;
      end
      nxt = m_state;
      if (!ENABLE) nxt = 0;
      else begin
         case (m_state)
            0: nxt = 1;
            1: if (m_time == InitCyc - 1) nxt = 2;
            2: if (ALIGNED) nxt = 3; else if (m_time == ToWins * Win - 1) nxt = 1;
            3: if (!ALIGNED) nxt = 1;
               else if (m_done) begin
                  if (bad) m_clean = 0;
                  else begin
                     m_clean++;
                     if (m_clean == UpWins) nxt = 4;
                  end
               end
            4: if (!ALIGNED) nxt = 1;
               else if (m_done) begin
                  if (!bad) m_bad = 0;
                  else begin
                     m_bad++;
                     if (m_bad == DownWins) nxt = 1;
                  end
               end
            default: nxt = 0;
         endcase
      end
      if (nxt != m_state) begin
         m_time = 0; m_clean = 0; m_bad = 0;
      end else begin
         m_time++;
      end
      m_state = nxt;
   endtask

   task automatic compare_all();
      check_eq("state", int'(STATE), m_state);
      check_eq("retrain", int'(RETRAIN), int'(m_state == 1));
      check_eq("link_up", int'(LINK_UP), int'(m_state == 4));
      check_eq("degraded", int'(DEGRADED), int'(m_state == 4 && m_bad != 0));
      check_eq("win_err", int'(WIN_ERR), m_win_err);
      check_eq("tot_err", int'(TOT_ERR), m_tot);
   endtask

   task automatic tick();
      @(posedge CLK);
      if (!RST) model_step();
      @(negedge CLK);
      compare_all();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset(input logic [7:0] e);
      #2;
      RST     = 1'b1;
      ERR_CNT = e;
      ENABLE  = 1'b0;
      ALIGNED = 1'b0;
      #1;
      check_eq("rst_state", int'(STATE), 0);
      check_eq("rst_retrain", int'(RETRAIN), 0);
      check_eq("rst_link_up", int'(LINK_UP), 0);
      check_eq("rst_tot", int'(TOT_ERR), 0);
      check_eq("rst_win_err", int'(WIN_ERR), 0);
      model_reset();
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic bring_up();
      int rt;
      rt     = 0;
      ENABLE = 1'b1;
      for (int i = 0; i < 200 && m_state != 4; i++) begin
         tick();
         if (RETRAIN) rt++;
         if (m_state == 2) ALIGNED = 1'b1;
      end
      check_eq("bringup_retrain_len", rt, InitCyc);
      check_eq("bringup_state", int'(STATE), 4);
   endtask

   task automatic wait_win();
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_done) break;
      end
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < 40; i++) begin
         if (m_state == 4 && m_pos == p) break;
         tick();
      end
   endtask

   initial begin
      int rt;
      int en_off;
      int al_off;
      n_checks = 0;
      n_pass   = 0;
      RST      = 1'b0;
      ENABLE   = 1'b0;
      ALIGNED  = 1'b0;
      ERR_CNT  = 8'd0;
      model_reset();

      // First sample after reset only seeds the delta pipeline.
      do_reset(8'd77);
      repeat (6) tick();
      check_eq("first_sample_tot", int'(TOT_ERR), 0);
      bring_up();
      check_eq("bringup_link_up", int'(LINK_UP), 1);

      // Counter wrap 250 -> 4 is ten errors.
      do_reset(8'd250);
      bring_up();
      wait_pos(4);
      ERR_CNT = 8'd4;
      tick();
      tick();
      check_eq("wrap_tot", int'(TOT_ERR), 10);
      wait_win();
      check_eq("wrap_win_err", int'(WIN_ERR), 10);
      check_eq("wrap_degraded", int'(DEGRADED), 1);
      // Second consecutive bad window forces retrain.
      ERR_CNT = ERR_CNT + 8'd3;
      wait_win();
      check_eq("degrade_state", int'(STATE), 1);
      check_eq("degrade_link_up", int'(LINK_UP), 0);
      rt = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!RETRAIN) break;
         rt++;
      end
      check_eq("degrade_retrain_len", rt, InitCyc);

      // A clean window between bad ones clears the streak.
      do_reset(8'd0);
      bring_up();
      wait_pos(4);
      ERR_CNT = ERR_CNT + 8'd3;
      wait_win();
      check_eq("bad1_degraded", int'(DEGRADED), 1);
      wait_win();
      check_eq("clean_degraded", int'(DEGRADED), 0);
      ERR_CNT = ERR_CNT + 8'd3;
      wait_win();
      check_eq("bad2_state", int'(STATE), 4);
      check_eq("bad2_degraded", int'(DEGRADED), 1);

      // Alignment loss, then wait-align timeout.
      ALIGNED = 1'b0;
      tick();
      check_eq("align_loss_state", int'(STATE), 1);
      check_eq("align_loss_link_up", int'(LINK_UP), 0);
      for (int i = 0; i < 20 && m_state != 2; i++) tick();
      repeat (63) tick();
      check_eq("timeout_minus1", int'(STATE), 2);
      tick();
      check_eq("timeout_state", int'(STATE), 1);

      // 300 errors saturate an 8-bit total.
      do_reset(8'd0);
      repeat (3) tick();
      ERR_CNT = 8'd150;
      tick();
      ERR_CNT = 8'd44;
      repeat (4) tick();
      check_eq("sat_tot", int'(TOT_ERR), 255);
      ERR_CNT = ERR_CNT + 8'd5;
      repeat (3) tick();
      check_eq("sat_hold", int'(TOT_ERR), 255);

      // ENABLE drop beats a coincident window end and alignment loss.
      do_reset(8'd0);
      bring_up();
      wait_pos(Win - 1);
      ENABLE  = 1'b0;
      ALIGNED = 1'b0;
      ERR_CNT = ERR_CNT + 8'd3;
      tick();
      check_eq("prio_state", int'(STATE), 0);
      check_eq("prio_link_up", int'(LINK_UP), 0);
      ENABLE = 1'b1;
      repeat (3) tick();
      ENABLE = 1'b0;
      tick();
      check_eq("init_trunc_retrain", int'(RETRAIN), 0);
      check_eq("init_trunc_state", int'(STATE), 0);
      ENABLE = 1'b1;
      repeat (3) tick();
      check_eq("mid_init_retrain", int'(RETRAIN), 1);
      do_reset(8'd9);

      // Randomized traffic with alignment and enable glitches.
      en_off = 0;
      al_off = 0;
      for (int seg = 0; seg < 12; seg++) begin
         int rate;
         rate = rates[$urandom_range(0, 3)];
         if (seg % 3 == 0) do_reset(8'($urandom_range(0, 255)));
         for (int c = 0; c < 250; c++) begin
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 399) == 0) en_off = $urandom_range(1, 6);
            if (al_off > 0) al_off--;
            else if ($urandom_range(0, 199) == 0) al_off = $urandom_range(1, 90);
            ENABLE  = (en_off == 0);
            ALIGNED = (al_off == 0);
            if ($urandom_range(0, 99) < rate) ERR_CNT = ERR_CNT + 8'($urandom_range(1, 3));
            if ($urandom_range(0, 599) == 0) ERR_CNT = ERR_CNT + 8'($urandom_range(100, 255));
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
